// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall sequencer.
package hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_t;

  localparam int unsigned REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch
// flushes and multi-cycle data-memory waits with timeout and perf counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_TIMEOUT = 255,
  parameter int unsigned TO_W         = 8,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ID_RS,
  input  logic [REG_AW-1:0] ID_RT,
  input  logic              ID_USES_RS,
  input  logic              ID_USES_RT,
  input  logic              EX_MEM_READ,
  input  logic [REG_AW-1:0] EX_RD,
  input  logic              EX_BRANCH_TAKEN,
  input  logic              MEM_DM_ACCESS,
  input  logic              DM_ACK,
  output logic              DM_REQ,
  output logic              PC_EN,
  output logic              IF_ID_EN,
  output logic              IF_ID_FLUSH,
  output logic              ID_EX_EN,
  output logic              ID_EX_FLUSH,
  output logic              EX_MEM_EN,
  output logic              MEM_WB_BUBBLE,
  output logic              DM_ERR,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [CNT_W-1:0]  FLUSH_CNT
);

  ctrl_state_t     state_q, state_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic            err_q, err_set;
  logic            load_use, hold;

  assign load_use = EX_MEM_READ && (EX_RD != REG_ZERO) &&
                    ((ID_USES_RS && (ID_RS == EX_RD)) ||
                     (ID_USES_RT && (ID_RT == EX_RD)));

  always_comb begin
    state_d       = state_q;
    tcnt_d        = tcnt_q;
    err_set       = 1'b0;
    hold          = 1'b0;
    DM_REQ        = 1'b0;
    PC_EN         = 1'b1;
    IF_ID_EN      = 1'b1;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_EN      = 1'b1;
    ID_EX_FLUSH   = 1'b0;
    EX_MEM_EN     = 1'b1;
    MEM_WB_BUBBLE = 1'b0;

    unique case (state_q)
      RUN: begin
        DM_REQ = MEM_DM_ACCESS;
        if (MEM_DM_ACCESS && !DM_ACK) begin
          hold    = 1'b1;
          state_d = MEM_WAIT;
          tcnt_d  = '0;
        end
      end
      MEM_WAIT: begin
        DM_REQ = 1'b1;
        if (DM_ACK) begin
          state_d = RUN;
        end else if (tcnt_q == TO_W'(WAIT_TIMEOUT - 1)) begin
          err_set = 1'b1;
          state_d = RUN;
        end else begin
          hold   = 1'b1;
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    // On release the held EX/ID contents are live again, so branch and
    // load-use resolve in the same cycle as the ack or timeout.
    if (hold) begin
      PC_EN         = 1'b0;
      IF_ID_EN      = 1'b0;
      ID_EX_EN      = 1'b0;
      EX_MEM_EN     = 1'b0;
      MEM_WB_BUBBLE = 1'b1;
    end else if (EX_BRANCH_TAKEN) begin
      IF_ID_FLUSH = 1'b1;
      ID_EX_FLUSH = 1'b1;
    end else if (load_use) begin
      PC_EN       = 1'b0;
      IF_ID_EN    = 1'b0;
      ID_EX_FLUSH = 1'b1;
    end

    if (rst) begin
      DM_REQ        = 1'b0;
      PC_EN         = 1'b1;
      IF_ID_EN      = 1'b1;
      IF_ID_FLUSH   = 1'b1;
      ID_EX_EN      = 1'b1;
      ID_EX_FLUSH   = 1'b1;
      EX_MEM_EN     = 1'b1;
      MEM_WB_BUBBLE = 1'b1;
      state_d       = RUN;
      tcnt_d        = '0;
      err_set       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign DM_ERR = err_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (!PC_EN),
    .q   (STALL_CNT)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (IF_ID_FLUSH),
    .q   (FLUSH_CNT)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected controls,
// a negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam int unsigned CW = 4;

  // {DM_REQ, PC_EN, IF_ID_EN, IF_ID_FLUSH, ID_EX_EN, ID_EX_FLUSH, EX_MEM_EN, MEM_WB_BUBBLE}
  localparam logic [7:0] C_NORM  = 8'b0110_1010;
  localparam logic [7:0] C_LU    = 8'b0000_1110;
  localparam logic [7:0] C_BR    = 8'b0111_1110;
  localparam logic [7:0] C_FRZ   = 8'b1000_0001;
  localparam logic [7:0] C_REL   = 8'b1110_1010;
  localparam logic [7:0] C_RELBR = 8'b1111_1110;
  localparam logic [7:0] C_RST   = 8'b0111_1111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic id_uses_rs = 1'b0, id_uses_rt = 1'b0, ex_mem_read = 1'b0;
  logic ex_branch_taken = 1'b0, mem_dm_access = 1'b0, dm_ack = 1'b0;
  logic dm_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_mem_en, mem_wb_bubble, dm_err;
  logic [CW-1:0] stall_cnt, flush_cnt;

  typedef struct {
    logic [7:0]    ctrl;
    logic          err;
    logic [CW-1:0] stall;
    logic [CW-1:0] flush;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int unsigned total = 0;
  int unsigned passed = 0;
  logic [CW-1:0] m_stall = '0, m_flush = '0;
  logic m_err = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl #(.WAIT_TIMEOUT(4), .TO_W(8), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .ID_RS           (id_rs),
    .ID_RT           (id_rt),
    .ID_USES_RS      (id_uses_rs),
    .ID_USES_RT      (id_uses_rt),
    .EX_MEM_READ     (ex_mem_read),
    .EX_RD           (ex_rd),
    .EX_BRANCH_TAKEN (ex_branch_taken),
    .MEM_DM_ACCESS   (mem_dm_access),
    .DM_ACK          (dm_ack),
    .DM_REQ          (dm_req),
    .PC_EN           (pc_en),
    .IF_ID_EN        (if_id_en),
    .IF_ID_FLUSH     (if_id_flush),
    .ID_EX_EN        (id_ex_en),
    .ID_EX_FLUSH     (id_ex_flush),
    .EX_MEM_EN       (ex_mem_en),
    .MEM_WB_BUBBLE   (mem_wb_bubble),
    .DM_ERR          (dm_err),
    .STALL_CNT       (stall_cnt),
    .FLUSH_CNT       (flush_cnt)
  );

  task automatic vec(input string nm, input logic r,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic mrd,
                     input logic [4:0] rd, input logic br,
                     input logic acc, input logic ack,
                     input logic [7:0] ectrl);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    ex_mem_read = mrd; ex_rd = rd; ex_branch_taken = br;
    mem_dm_access = acc; dm_ack = ack;
    x.ctrl = ectrl; x.err = m_err; x.stall = m_stall; x.flush = m_flush;
    x.name = nm;
    exp_q.push_back(x);
    if (r) begin
      m_stall = '0; m_flush = '0; m_err = 1'b0;
    end else begin
      if (!ectrl[6] && m_stall != '1) m_stall = m_stall + 1'b1;
      if (ectrl[4] && m_flush != '1) m_flush = m_flush + 1'b1;
    end
  endtask

  task automatic idle(input string nm);
    vec(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NORM);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      total++;
      if ({dm_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
           ex_mem_en, mem_wb_bubble} !== e.ctrl)
        $display("FAIL %s ctrl got=%b exp=%b", e.name,
                 {dm_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                  ex_mem_en, mem_wb_bubble}, e.ctrl);
      else passed++;
      total++;
      if ({dm_err, stall_cnt, flush_cnt} !== {e.err, e.stall, e.flush})
        $display("FAIL %s stat got err=%b stall=%0d flush=%0d exp err=%b stall=%0d flush=%0d",
                 e.name, dm_err, stall_cnt, flush_cnt, e.err, e.stall, e.flush);
      else passed++;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    idle("reset_exit");
    // load-use on rs, then register 0, rt match, and unused-operand match
    vec("lu_rs", 0, 5, 0, 1, 0, 1, 5, 0, 0, 0, C_LU);
    idle("lu_after");
    vec("lu_rd0", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, C_NORM);
    vec("lu_rt", 0, 0, 7, 0, 1, 1, 7, 0, 0, 0, C_LU);
    vec("lu_unused", 0, 9, 0, 0, 0, 1, 9, 0, 0, 0, C_NORM);
    // branch beats load-use
    vec("br_lu", 0, 5, 0, 1, 0, 1, 5, 1, 0, 0, C_BR);
    idle("br_after");
    // three-cycle memory wait, ack on the fourth
    vec("mw0", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ);
    vec("mw1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ);
    vec("mw2", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ);
    vec("mw_ack", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_REL);
    idle("mw_after");
    // zero-wait access and stray ack
    vec("zw", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_REL);
    idle("zw_after");
    vec("stray_ack", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_NORM);
    // release carries a pending branch
    vec("mwb0", 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, C_FRZ);
    vec("mwb_ack", 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, C_RELBR);
    idle("mwb_after");
    // timeout after four frozen cycles
    for (int unsigned i = 0; i < 4; i++)
      vec("to_frz", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ);
    vec("to_rel", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_REL);
    m_err = 1'b1;
    idle("to_err");
    idle("to_sticky");
    // reset in the second cycle of a wait
    vec("rw0", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ);
    vec("rw1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_FRZ);
    vec("rw_rst", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RST);
    idle("rw_run");
    // counter saturation
    for (int unsigned i = 0; i < 20; i++)
      vec("sat", 0, 3, 0, 1, 0, 1, 3, 0, 0, 0, C_LU);
    idle("sat_final");
    for (int unsigned i = 0; i < 10 && exp_q.size() != 0; i++)
      @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Drives the enable and flush/bubble controls of the PC and of the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers.
- Resolves three events: load-use hazards, taken-branch flushes, and multi-cycle data-memory accesses via a req/ack handshake.
- Exposes saturating stall/flush performance counters and a sticky memory-timeout error flag.

Parameters:
- WAIT_TIMEOUT, 255: maximum cycles in MEM_WAIT before forced release. Legal range 1..2^TO_W-1.
- TO_W, 8: width of the timeout counter.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- ID_RS  in  5  rs field of the instruction in ID.
- ID_RT  in  5  rt field of the instruction in ID.
- ID_USES_RS  in  1  instruction in ID reads rs.
- ID_USES_RT  in  1  instruction in ID reads rt.
- EX_MEM_READ  in  1  instruction in EX is a load.
- EX_RD  in  5  destination register of the instruction in EX.
- EX_BRANCH_TAKEN  in  1  branch/jump resolved taken in EX.
- MEM_DM_ACCESS  in  1  instruction in MEM accesses data memory.
- DM_ACK  in  1  data memory completion pulse.
- DM_REQ  out  1  data memory request.
- PC_EN  out  1  PC register load enable.
- IF_ID_EN  out  1  IF_ID register load enable.
- IF_ID_FLUSH  out  1  IF_ID register clear.
- ID_EX_EN  out  1  ID_EX register load enable.
- ID_EX_FLUSH  out  1  ID_EX register clear (bubble).
- EX_MEM_EN  out  1  EX_MEM register load enable.
- MEM_WB_BUBBLE  out  1  MEM_WB loads a NOP (RF write disabled).
- DM_ERR  out  1  sticky timeout flag.
- STALL_CNT  out  CNT_W  cycles with PC_EN=0.
- FLUSH_CNT  out  CNT_W  cycles with IF_ID_FLUSH=1.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- State: state, timeout counter, DM_ERR and both performance counters are registered. All pipeline controls are combinational from state and inputs.
- Reset values: while rst=1:
  - State is RUN.
  - Timeout counter, STALL_CNT, FLUSH_CNT and DM_ERR are all 0.
  - Outputs are forced to PC_EN=1, IF_ID_EN=1, ID_EX_EN=1, EX_MEM_EN=1, IF_ID_FLUSH=1, ID_EX_FLUSH=1, MEM_WB_BUBBLE=1, DM_REQ=0.
- load_use = EX_MEM_READ && EX_RD!=0 && ((ID_USES_RS && ID_RS==EX_RD) || (ID_USES_RT && ID_RT==EX_RD)).
- State RUN:
  - DM_REQ = MEM_DM_ACCESS.
  - If MEM_DM_ACCESS && !DM_ACK: freeze. PC_EN=IF_ID_EN=ID_EX_EN=EX_MEM_EN=0, MEM_WB_BUBBLE=1, no flushes. Next state MEM_WAIT, timeout counter cleared to 0.
  - Else if EX_BRANCH_TAKEN: IF_ID_FLUSH=1, ID_EX_FLUSH=1, all enables 1. Branch wins over load_use.
  - Else if load_use: PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1, EX_MEM_EN=1. This is a one-cycle bubble; the hazard clears naturally next cycle.
  - Else: all enables 1, no flush, no bubble.
  - Zero-wait memory (DM_ACK in the same cycle as the access) causes no stall.
- State MEM_WAIT:
  - DM_REQ=1. Full freeze as above. Branch and load_use are ignored because the EX and ID contents are held.
  - DM_ACK=1: release this cycle. Enables follow the RUN rules except the memory term; pending branch/load_use apply in this cycle. Next state RUN.
  - Timeout counter reaches WAIT_TIMEOUT-1 without ack: DM_ERR<=1 (sticky until rst), release exactly as for ack, next state RUN.
  - Otherwise the timeout counter increments.
- DM_ACK is ignored in RUN when MEM_DM_ACCESS=0.
- Reset asserted mid-wait: the next state is RUN and DM_REQ drops in the same cycle rst is seen.
- Performance counters:
  - STALL_CNT increments on each non-reset cycle with PC_EN=0.
  - FLUSH_CNT increments on each non-reset cycle with IF_ID_FLUSH=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- No latency is added to the pipeline: controls take effect at the same rising edge the pipeline registers sample.

Decomposition:
- hazard_ctrl_pkg:
  - state enum ctrl_state_t {RUN, MEM_WAIT}.
  - REG_AW=5.
  - REG_ZERO=5'd0.
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, q), instantiated twice for STALL_CNT and FLUSH_CNT.

Test Plan:
- Load-use: EX_MEM_READ=1, EX_RD=5, ID_RS=5, ID_USES_RS=1 for one cycle -> PC_EN=0, IF_ID_EN=0, ID_EX_FLUSH=1, EX_MEM_EN=1 for exactly 1 cycle, STALL_CNT=1. Repeat with EX_RD=0 -> no stall.
- Branch plus load-use in the same cycle -> IF_ID_FLUSH=ID_EX_FLUSH=1, PC_EN=1, FLUSH_CNT=1, STALL_CNT unchanged.
- Memory wait: MEM_DM_ACCESS=1, DM_ACK pulsed 3 cycles after the access starts -> DM_REQ=1 for 4 cycles, freeze and MEM_WB_BUBBLE=1 for 3 cycles, release on the ack cycle, STALL_CNT=3.
- Zero-wait: MEM_DM_ACCESS=1 with DM_ACK=1 in the same cycle -> no freeze, state stays RUN.
- Timeout: WAIT_TIMEOUT=4, no ack -> freeze for 4 cycles, then release with DM_ERR=1 held until rst.
- Reset mid-MEM_WAIT and saturation:
  - rst=1 in cycle 2 of a wait -> DM_REQ=0 in the same cycle, counters 0, state RUN next cycle.
  - CNT_W=4 with 20 stall cycles -> STALL_CNT=15.
